instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/proc_pkg.sv | 23 ++
 rtl/instr_fetch_if.sv | 16 +
 rtl/fetch_skid.sv | 44 ++++
 rtl/instr_fetch.sv | 128 ++++++++++++
 tb/tb_instr_fetch.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the instruction fetch unit: opcodes, FSM states and
// default address/instruction widths.
package proc_pkg;

    localparam int PC_W_DEF    = 12;
    localparam int INSTR_W_DEF = 16;

    typedef enum logic [3:0] {
        OP_CMP = 4'b1000,
        OP_MOV = 4'b1011,
        OP_LD  = 4'b1100,
        OP_ST  = 4'b1101,
        OP_BT  = 4'b1110,
        OP_NOP = 4'b1111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_REDIRECT
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory read port: address/read request out, data back one cycle later.
interface instr_fetch_if
    import proc_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) ();

    logic [PC_W-1:0]    imem_addr;
    logic               imem_rd;
    logic [INSTR_W-1:0] imem_data;

    modport master (output imem_addr, output imem_rd, input imem_data);
    modport slave  (input imem_addr, input imem_rd, output imem_data);

endinterface

// File: rtl/fetch_skid.sv
// One-entry skid register that parks a fetched word while the issue stage is stalled.
module fetch_skid #(
    parameter int W = 28
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic         valid,
    output logic [W-1:0] dout
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload is only meaningful while valid_q is set, so it carries no reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign valid = valid_q;
    assign dout  = data_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: sequential fetch with one-cycle memory latency, stall skid,
// compare flag and taken-branch redirect (two bubbles).
module instr_fetch
    import proc_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stall,
    instr_fetch_if.master      mem,
    output logic [INSTR_W-1:0] instr_out,
    output logic [3:0]         opcode_out,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc_out,
    input  logic               branch,
    input  logic               cmp_en,
    input  logic               cmp_result,
    output logic               flag,
    output logic               busy
);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               req_q;
    logic [PC_W-1:0]    req_addr_q;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [PC_W-1:0]    ir_pc_q, ir_pc_d;
    logic               vld_q, vld_d;
    logic               flag_q, flag_d;

    logic rd, advance, taken, live;
    logic skid_load, skid_clear, skid_vld;
    logic [PC_W+INSTR_W-1:0] skid_dout;

    fetch_skid #(.W(PC_W + INSTR_W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clear),
        .din   ({req_addr_q, mem.imem_data}),
        .valid (skid_vld),
        .dout  (skid_dout)
    );

    always_comb begin
        rd      = (state_q != ST_IDLE) && !stall;
        advance = vld_q && !stall;
        // flag_q is the value before this cycle's compare update
        taken   = advance && branch && flag_q;
        // the word returning during REDIRECT belongs to the abandoned sequential path
        live    = req_q && (state_q != ST_REDIRECT);

        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start) state_d = ST_RUN;
            ST_RUN:      if (taken) state_d = ST_REDIRECT;
            ST_REDIRECT: state_d = ST_RUN;
            default:     state_d = ST_IDLE;
        endcase

        pc_d = pc_q;
        if (taken) begin
            pc_d = ir_q[PC_W-1:0];
        end else if (rd) begin
            pc_d = pc_q + PC_W'(1);
        end

        flag_d = (advance && cmp_en) ? cmp_result : flag_q;

        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        vld_d      = vld_q;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (taken) begin
            vld_d      = 1'b0;
            skid_clear = 1'b1;
        end else if (stall) begin
            skid_load = live;
        end else if (skid_vld) begin
            // a parked word is older than anything arriving now, so it issues first
            {ir_pc_d, ir_d} = skid_dout;
            vld_d           = 1'b1;
            skid_clear      = 1'b1;
        end else begin
            vld_d = live;
            if (live) begin
                ir_d    = mem.imem_data;
                ir_pc_d = req_addr_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            req_q      <= 1'b0;
            req_addr_q <= '0;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            vld_q      <= 1'b0;
            flag_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= rd;
            req_addr_q <= pc_q;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            vld_q      <= vld_d;
            flag_q     <= flag_d;
        end
    end

    assign mem.imem_addr = pc_q;
    assign mem.imem_rd   = rd;
    assign instr_out     = ir_q;
    assign instr_valid   = vld_q;
    assign pc_out        = ir_pc_q;
    assign opcode_out    = vld_q ? ir_q[INSTR_W-1 -: 4] : OP_NOP;
    assign flag          = flag_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, stall/skid, compare+branch,
// pc wrap and asynchronous reset with a parked word.
module tb_instr_fetch;
    import proc_pkg::*;

    localparam int PC_W    = 12;
    localparam int INSTR_W = 16;

    logic               clk = 1'b0;
    logic               rst, start, stall, cmp_result;
    logic [INSTR_W-1:0] instr_out;
    logic [3:0]         opcode_out;
    logic               instr_valid;
    logic [PC_W-1:0]    pc_out;
    logic               branch, cmp_en, flag, busy;

    logic [INSTR_W-1:0] mem [0:(1<<PC_W)-1];
    int n_cmp = 0;
    int n_bad = 0;

    instr_fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stall       (stall),
        .mem         (bus),
        .instr_out   (instr_out),
        .opcode_out  (opcode_out),
        .instr_valid (instr_valid),
        .pc_out      (pc_out),
        .branch      (branch),
        .cmp_en      (cmp_en),
        .cmp_result  (cmp_result),
        .flag        (flag),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // memory: one-cycle read latency
    always @(posedge clk) bus.imem_data <= mem[bus.imem_addr];

    // downstream decoder of the issued instruction
    assign branch = (opcode_out == OP_BT);
    assign cmp_en = (opcode_out == OP_CMP);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_mem();
        for (int i = 0; i < (1 << PC_W); i++) mem[i] = {4'h2, 12'(i)};
    endtask

    // advance to the next cycle, apply inputs, let combinational outputs settle
    task automatic step(input logic s_start, input logic s_stall);
        @(posedge clk);
        #1;
        start = s_start;
        stall = s_stall;
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst   = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        #1;
        chk("rst_vld",  32'(instr_valid),  0);
        chk("rst_opc",  32'(opcode_out),   'hF);
        chk("rst_pcout",32'(pc_out),       0);
        chk("rst_rd",   32'(bus.imem_rd),  0);
        chk("rst_busy", 32'(busy),         0);
        chk("rst_flag", 32'(flag),         0);
        chk("rst_addr", 32'(bus.imem_addr),0);
        chk("rst_ir",   32'(instr_out),    0);
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic issue(input string tag, input int pc, input int word);
        chk({tag, "_vld"},   32'(instr_valid), 1);
        chk({tag, "_pcout"}, 32'(pc_out),      32'(pc));
        chk({tag, "_ir"},    32'(instr_out),   32'(word));
    endtask

    // program: CMP at 2, BT 0x040 at 3; returns in the cycle CMP issues
    task automatic prep_branch(input logic res);
        load_mem();
        mem[2]     = 16'h8000;
        mem[3]     = 16'hE040;
        mem['h040] = 16'h3040;
        cmp_result = res;
        do_reset();
        step(1, 0);
        step(0, 0);
        step(0, 0);
        for (int k = 0; k <= 2; k++) step(0, 0);
        issue("cmp", 2, 'h8000);
        chk("cmp_opc", 32'(opcode_out), 'h8);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        stall      = 1'b0;
        cmp_result = 1'b0;

        // sequential fetch, then a three-cycle stall at pc_out=4
        load_mem();
        do_reset();
        step(1, 0);
        chk("idle_busy", 32'(busy), 0);
        step(0, 0);
        chk("t1_rd",   32'(bus.imem_rd),   1);
        chk("t1_addr", 32'(bus.imem_addr), 0);
        chk("t1_busy", 32'(busy),          1);
        chk("t1_vld",  32'(instr_valid),   0);
        step(0, 0);
        chk("t2_vld", 32'(instr_valid), 0);
        chk("t2_opc", 32'(opcode_out),  'hF);
        for (int k = 0; k <= 4; k++) begin
            step(0, k == 4);
            issue("seq", k, 'h2000 + k);
            chk("seq_opc", 32'(opcode_out), 'h2);
        end
        chk("stall_rd",   32'(bus.imem_rd),   0);
        chk("stall_addr", 32'(bus.imem_addr), 6);
        for (int j = 0; j < 2; j++) begin
            step(0, 1);
            issue("stall_hold", 4, 'h2004);
        end
        step(0, 0);
        issue("release", 4, 'h2004);
        chk("release_addr", 32'(bus.imem_addr), 6);
        for (int k = 5; k <= 8; k++) begin
            step(0, 0);
            issue("after_stall", k, 'h2000 + k);
        end

        // taken branch
        prep_branch(1);
        step(0, 0);
        issue("bt", 3, 'hE040);
        chk("bt_flag", 32'(flag), 1);
        step(0, 0);
        chk("redir_vld",  32'(instr_valid),   0);
        chk("redir_opc",  32'(opcode_out),    'hF);
        chk("redir_addr", 32'(bus.imem_addr), 'h040);
        chk("redir_rd",   32'(bus.imem_rd),   1);
        step(0, 0);
        chk("bubble2_vld", 32'(instr_valid), 0);
        step(0, 0);
        issue("target", 'h040, 'h3040);
        step(0, 0);
        issue("target1", 'h041, 'h2041);

        // not-taken branch
        prep_branch(0);
        step(0, 0);
        issue("bt_nt", 3, 'hE040);
        chk("nt_flag", 32'(flag), 0);
        step(0, 0);
        issue("nt_next", 4, 'h2004);
        step(0, 0);
        issue("nt_next1", 5, 'h2005);

        // taken branch held by stall
        prep_branch(1);
        step(0, 1);
        issue("bts_hold0", 3, 'hE040);
        chk("bts_rd", 32'(bus.imem_rd), 0);
        step(0, 1);
        issue("bts_hold1", 3, 'hE040);
        step(0, 0);
        issue("bts_rel", 3, 'hE040);
        chk("bts_rel_addr", 32'(bus.imem_addr), 5);
        step(0, 0);
        chk("bts_bub0_vld", 32'(instr_valid),   0);
        chk("bts_bub0_addr",32'(bus.imem_addr), 'h040);
        step(0, 0);
        chk("bts_bub1_vld", 32'(instr_valid), 0);
        step(0, 0);
        issue("bts_target", 'h040, 'h3040);

        // reset with a word parked in the skid, then restart
        load_mem();
        do_reset();
        step(1, 0);
        step(0, 0);
        step(0, 0);
        step(0, 0);
        issue("pre_rst0", 0, 'h2000);
        step(0, 1);
        issue("pre_rst1", 1, 'h2001);
        step(0, 1);
        do_reset();
        step(0, 0);
        chk("norestart_rd",   32'(bus.imem_rd), 0);
        chk("norestart_busy", 32'(busy),        0);
        step(0, 0);
        chk("norestart_vld", 32'(instr_valid), 0);
        step(1, 0);
        step(0, 0);
        chk("restart_addr", 32'(bus.imem_addr), 0);
        chk("restart_rd",   32'(bus.imem_rd),   1);
        step(0, 0);
        chk("restart_vld0", 32'(instr_valid), 0);
        step(0, 0);
        issue("restart0", 0, 'h2000);
        step(0, 0);
        issue("restart1", 1, 'h2001);

        // pc wrap via branch to 0xFFD
        load_mem();
        mem[0]     = 16'h8000;
        mem[1]     = 16'hEFFD;
        mem['hFFD] = 16'h5FFD;
        mem['hFFE] = 16'h5FFE;
        mem['hFFF] = 16'h5FFF;
        cmp_result = 1'b1;
        do_reset();
        step(1, 0);
        step(0, 0);
        step(0, 0);
        step(0, 0);
        issue("wrap_cmp", 0, 'h8000);
        step(0, 0);
        issue("wrap_bt", 1, 'hEFFD);
        step(0, 0);
        chk("wrap_addr_ffd", 32'(bus.imem_addr), 'hFFD);
        step(0, 0);
        chk("wrap_addr_ffe", 32'(bus.imem_addr), 'hFFE);
        step(0, 0);
        issue("wrap_ffd", 'hFFD, 'h5FFD);
        chk("wrap_addr_fff", 32'(bus.imem_addr), 'hFFF);
        step(0, 0);
        issue("wrap_ffe", 'hFFE, 'h5FFE);
        chk("wrap_addr_000", 32'(bus.imem_addr), 0);
        step(0, 0);
        issue("wrap_fff", 'hFFF, 'h5FFF);
        step(0, 0);
        issue("wrap_000", 0, 'h8000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
